// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / load-store) arbiter for a single-port fixed-latency memory.
// Optional ARB_PERF_CNT_EN adds stall-cycle counters perf_if_wait / perf_mem_wait.
module mem_port_arbiter #(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_valid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_u_b_h_w,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_u_b_h_w,
    input  logic [31:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0] perf_if_wait,
    output logic [31:0] perf_mem_wait
`endif
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    state_t      state_q, state_d;
    logic        owner_q;
    logic        we_q;
    logic        first_q;
    logic [3:0]  lat_cnt;
    logic [3:0]  starve_cnt;
    logic        grant_i, grant_d;

    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        case (state_q)
            IDLE: begin
                // A fetch that has waited out STARVE_LIMIT data grants goes first.
                if (i_req && starve_cnt == 4'(STARVE_LIMIT)) grant_i = 1'b1;
                else if (d_req)                              grant_d = 1'b1;
                else if (i_req)                              grant_i = 1'b1;
                if (grant_i || grant_d) state_d = ACCESS;
            end
            ACCESS:  if (lat_cnt == 4'd0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_FETCH;
            we_q        <= 1'b0;
            first_q     <= 1'b0;
            lat_cnt     <= 4'd0;
            starve_cnt  <= 4'd0;
            mem_addr    <= 32'd0;
            mem_wdata   <= 32'd0;
            mem_u_b_h_w <= 3'd0;
            i_rdata     <= 32'd0;
            d_rdata     <= 32'd0;
        end else begin
            state_q <= state_d;
            if (grant_i || grant_d) begin
                owner_q     <= grant_d ? OWN_DATA : OWN_FETCH;
                we_q        <= grant_d & d_we;
                first_q     <= 1'b1;
                lat_cnt     <= 4'(MEM_LATENCY - 1);
                mem_addr    <= grant_d ? d_addr : i_addr;
                mem_wdata   <= grant_d ? d_wdata : 32'd0;
                mem_u_b_h_w <= grant_d ? d_u_b_h_w : 3'b010;
            end
            if (grant_i)
                starve_cnt <= 4'd0;
            else if (grant_d && i_req && starve_cnt != 4'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + 4'd1;
            if (state_q == ACCESS) begin
                first_q <= 1'b0;
                if (lat_cnt != 4'd0)
                    lat_cnt <= lat_cnt - 4'd1;
                else if (owner_q == OWN_DATA)
                    d_rdata <= we_q ? 32'd0 : mem_rdata;
                else
                    i_rdata <= mem_rdata;
            end
        end
    end

    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = mem_en & first_q & we_q;
    assign i_valid   = (state_q == RESP) & (owner_q == OWN_FETCH);
    assign d_valid   = (state_q == RESP) & (owner_q == OWN_DATA);
    assign stall_if  = i_req & ~i_valid;
    assign stall_mem = d_req & ~d_valid;

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_if_wait  <= 32'd0;
            perf_mem_wait <= 32'd0;
        end else begin
            perf_if_wait  <= perf_if_wait + 32'(stall_if);
            perf_mem_wait <= perf_mem_wait + 32'(stall_mem);
        end
    end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, multi-cycle corner sequences,
// and random traffic against a transaction-timeline reference model.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [2:0]  d_sz;
    logic        i_valid, d_valid, stall_if, stall_mem, mem_en, mem_we;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_sz;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_wait, perf_mem_wait;
`endif

    // second instance, MEM_LATENCY=1, for back-to-back throughput
    logic        l1_d_req;
    logic        l1_i_valid, l1_d_valid, l1_stall_if, l1_stall_mem, l1_mem_en, l1_mem_we;
    logic [31:0] l1_i_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
    logic [2:0]  l1_mem_sz;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] l1_perf_if, l1_perf_mem;
`endif

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a == 32'h10) ? 32'h0000_0093 : {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    assign mem_rdata    = mem_f(mem_addr);
    assign l1_mem_rdata = mem_f(l1_mem_addr);

    mem_port_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_u_b_h_w(d_sz),
        .d_valid(d_valid), .d_rdata(d_rdata), .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_u_b_h_w(mem_sz), .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
        , .perf_if_wait(perf_if_wait), .perf_mem_wait(perf_mem_wait)
`endif
    );

    mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) dut1 (
        .clk(clk), .rst(rst),
        .i_req(1'b0), .i_addr(32'd0), .i_valid(l1_i_valid), .i_rdata(l1_i_rdata),
        .d_req(l1_d_req), .d_we(1'b0), .d_addr(32'h80), .d_wdata(32'd0), .d_u_b_h_w(3'b010),
        .d_valid(l1_d_valid), .d_rdata(l1_d_rdata), .stall_if(l1_stall_if), .stall_mem(l1_stall_mem),
        .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
        .mem_u_b_h_w(l1_mem_sz), .mem_rdata(l1_mem_rdata)
`ifdef ARB_PERF_CNT_EN
        , .perf_if_wait(l1_perf_if), .perf_mem_wait(l1_perf_mem)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; i_req = 0; d_req = 0; d_we = 0; l1_d_req = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; d_sz = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        logic        ir, dr;
        logic        iv, dv, en, we, sif, smem;
        logic [31:0] addr;
    } vec_t;
    vec_t tbl[9];

    // reference model state (transaction timeline)
    localparam int L = 2;
    localparam int SL = 4;
    bit          g_act, g_d, g_we, busy, acc, resp, eiv, edv, piv, pdv;
    logic [31:0] g_addr, g_wdata, ei_rd, ed_rd;
    logic [2:0]  g_sz;
    int          g_t, starve;

    initial begin
        // {i_req, d_req, i_valid, d_valid, mem_en, mem_we, stall_if, stall_mem, mem_addr}
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h10};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h10};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h20};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h20};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20};

        do_reset();
        @(negedge clk);
        chk("reset_outputs", {i_valid, d_valid, mem_en, mem_we, stall_if, stall_mem}, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_rdata", i_rdata | d_rdata, 0);
        next_cycle();

        // ---- directed table: one fetch, then one store
        i_addr = 32'h10; d_addr = 32'h20; d_we = 1'b1; d_wdata = 32'hDEAD_BEEF; d_sz = 3'b010;
        for (int i = 0; i < 9; i++) begin
            i_req = tbl[i].ir; d_req = tbl[i].dr;
            @(negedge clk);
            chk($sformatf("tbl%0d_i_valid", i), i_valid, tbl[i].iv);
            chk($sformatf("tbl%0d_d_valid", i), d_valid, tbl[i].dv);
            chk($sformatf("tbl%0d_mem_en", i), mem_en, tbl[i].en);
            chk($sformatf("tbl%0d_mem_we", i), mem_we, tbl[i].we);
            chk($sformatf("tbl%0d_stall_if", i), stall_if, tbl[i].sif);
            chk($sformatf("tbl%0d_stall_mem", i), stall_mem, tbl[i].smem);
            chk($sformatf("tbl%0d_mem_addr", i), mem_addr, tbl[i].addr);
            if (i == 3) begin
                chk("fetch_i_rdata", i_rdata, 32'h93);
`ifdef ARB_PERF_CNT_EN
                chk("perf_if_wait", perf_if_wait, 3);
                chk("perf_mem_wait", perf_mem_wait, 0);
`endif
            end
            if (i == 5) begin
                chk("store_wdata", mem_wdata, 32'hDEAD_BEEF);
                chk("store_size", mem_sz, 3'b010);
            end
            if (i == 7) chk("store_d_rdata", d_rdata, 0);
            if (i == 8) begin
                chk("i_rdata_held", i_rdata, 32'h93);
`ifdef ARB_PERF_CNT_EN
                chk("perf_mem_wait_after_store", perf_mem_wait, 3);
`endif
            end
            next_cycle();
        end

        // ---- starvation: both requesters held, expect D,D,D,D,I repeating
        begin
            string order, exp_order;
            bit prev_en;
            int grants, cyc;
            do_reset();
            i_addr = 32'h100; d_addr = 32'h200; d_we = 1'b0; i_req = 1; d_req = 1;
            order = ""; exp_order = "DDDDIDDDDI";
            prev_en = 0; grants = 0; cyc = 0;
            while (grants < 10 && cyc < 200) begin
                @(negedge clk);
                if (mem_en && !prev_en) begin
                    grants++;
                    if (mem_addr == 32'h100) begin
                        order = {order, "I"};
                        chk("starve_cnt_after_I", 32'(dut.starve_cnt), 0);
                    end else order = {order, "D"};
                end
                prev_en = mem_en;
                cyc++;
                next_cycle();
            end
            checks++;
            if (order != exp_order) begin
                errors++;
                $display("FAIL grant_order: got %s expected %s", order, exp_order);
            end
        end

        // ---- reset during a load ACCESS: access abandoned, fresh access afterwards
        do_reset();
        d_req = 1; d_we = 0; d_addr = 32'h40;
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_pre_en", mem_en, 1);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_en", mem_en, 0);
        chk("rst_mid_dvalid0", d_valid, 0);
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            @(negedge clk);
            chk($sformatf("rst_fresh_dvalid%0d", k), d_valid, (k == 3));
        end
        chk("rst_fresh_rdata", d_rdata, mem_f(32'h40));
        next_cycle();

        // ---- MEM_LATENCY=1 with d_req held: valid every 3 cycles
        do_reset();
        l1_d_req = 1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            chk($sformatf("l1_dvalid_c%0d", c), l1_d_valid, (c % 3 == 2));
            next_cycle();
        end
        l1_d_req = 0;

        // ---- random traffic vs timeline model
        do_reset();
        g_act = 0; starve = 0; ei_rd = 0; ed_rd = 0; piv = 0; pdv = 0;
        for (int c = 0; c < 1500; c++) begin
            // requester drivers: after a completion drop or issue a new request
            if (piv) begin
                i_req = $urandom_range(1); i_addr = {$urandom_range(255), 2'b00};
            end else if (!i_req) begin
                if ($urandom_range(4) < 2) begin i_req = 1; i_addr = {$urandom_range(255), 2'b00}; end
            end else if ($urandom_range(31) == 0) i_req = 0;
            if (pdv || (!d_req && $urandom_range(4) < 2)) begin
                d_req = pdv ? 1'($urandom_range(1)) : 1'b1;
                d_we = $urandom_range(1); d_addr = {$urandom_range(255), 2'b00};
                d_wdata = $urandom; d_sz = $urandom_range(7);
            end else if (d_req && $urandom_range(31) == 0) d_req = 0;

            @(negedge clk);
            busy = g_act && (c <= g_t + L + 1);
            if (!busy) begin
                g_act = 0;
                if (i_req || d_req) begin
                    g_d = !(i_req && starve == SL) && d_req;
                    if (!g_d) starve = 0;
                    else if (i_req && starve < SL) starve++;
                    g_addr = g_d ? d_addr : i_addr;
                    g_we = g_d && d_we; g_wdata = d_wdata; g_sz = d_sz;
                    g_t = c; g_act = 1;
                end
            end
            acc  = g_act && c > g_t && c <= g_t + L;
            resp = g_act && c == g_t + L + 1;
            eiv = resp && !g_d;
            edv = resp && g_d;
            if (eiv) ei_rd = mem_f(g_addr);
            if (edv) ed_rd = g_we ? 32'd0 : mem_f(g_addr);
            chk("rnd_ctrl", {i_valid, d_valid, mem_en, mem_we, stall_if, stall_mem},
                {eiv, edv, acc, acc && c == g_t + 1 && g_we, i_req && !eiv, d_req && !edv});
            if (acc) chk("rnd_mem_addr", mem_addr, g_addr);
            if (acc && g_d) chk("rnd_mem_size", mem_sz, g_sz);
            if (acc && g_we) chk("rnd_mem_wdata", mem_wdata, g_wdata);
            chk("rnd_i_rdata", i_rdata, ei_rd);
            chk("rnd_d_rdata", d_rdata, ed_rd);
            piv = eiv; pdv = edv;
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
